// File: rtl/dmem_arbiter_if.sv
// Bus interfaces around the data-memory arbiter: core MEM-stage port,
// accelerator load/store port and the shared memory port.
interface dmem_core_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              core_rd;
  logic              core_wr;
  logic [2:0]        core_func3;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;

  modport master (output core_rd, core_wr, core_func3, core_addr, core_wdata,
                  input  core_rdata, core_stall);
  modport slave  (input  core_rd, core_wr, core_func3, core_addr, core_wdata,
                  output core_rdata, core_stall);
endinterface

interface dmem_acc_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              acc_req_valid;
  logic              acc_req_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_req_ready;
  logic              acc_rsp_valid;
  logic [DATA_W-1:0] acc_rdata;

  modport master (output acc_req_valid, acc_req_we, acc_addr, acc_wdata,
                  input  acc_req_ready, acc_rsp_valid, acc_rdata);
  modport slave  (input  acc_req_valid, acc_req_we, acc_addr, acc_wdata,
                  output acc_req_ready, acc_rsp_valid, acc_rdata);
endinterface

interface dmem_mem_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [2:0]        mem_func3;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req_valid, mem_we, mem_func3, mem_addr, mem_wdata,
                  input  mem_req_ready, mem_rsp_valid, mem_rdata);
  modport slave  (input  mem_req_valid, mem_we, mem_func3, mem_addr, mem_wdata,
                  output mem_req_ready, mem_rsp_valid, mem_rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the core MEM stage (priority) and the
// GEMM accelerator load/store engine, one outstanding transaction at a time.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  dmem_core_if.slave core,
  dmem_acc_if.slave  acc,
  dmem_mem_if.master mem
);

  localparam int unsigned CNT_W      = 4;
  localparam logic [2:0]  FUNC3_WORD = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_acc_q, owner_acc_d;
  logic              we_q, we_d;
  logic [2:0]        func3_q, func3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  starve_q, starve_d;

  logic core_req;
  logic starved;
  logic grant_acc;
  logic grant_core;
  logic rsp_hit;

  // Arbitration is only live in IDLE; the starved accelerator overrides the core.
  assign core_req   = core.core_rd | core.core_wr;
  assign starved    = (starve_q == CNT_W'(STARVE_LIMIT));
  assign grant_acc  = (state_q == S_IDLE) & acc.acc_req_valid & (~core_req | starved);
  assign grant_core = (state_q == S_IDLE) & core_req & ~grant_acc;
  assign rsp_hit    = (state_q == S_WAIT) & mem.mem_rsp_valid;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant_acc || grant_core) state_d = S_ISSUE;
      S_ISSUE: if (mem.mem_req_ready)       state_d = S_WAIT;
      S_WAIT:  if (mem.mem_rsp_valid)       state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; the request side is driven purely from captured registers.
  always_comb begin
    mem.mem_req_valid = (state_q == S_ISSUE);
    mem.mem_we        = we_q;
    mem.mem_func3     = func3_q;
    mem.mem_addr      = addr_q;
    mem.mem_wdata     = wdata_q;
    core.core_stall   = core_req & ~(rsp_hit & ~owner_acc_q);
    core.core_rdata   = mem.mem_rdata;
    acc.acc_req_ready = grant_acc & reset;
    acc.acc_rsp_valid = rsp_hit & owner_acc_q;
    acc.acc_rdata     = mem.mem_rdata;
  end

  // Winner capture and starvation counter update
  always_comb begin
    owner_acc_d = owner_acc_q;
    we_d        = we_q;
    func3_d     = func3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    starve_d    = starve_q;
    if (grant_acc) begin
      owner_acc_d = 1'b1;
      we_d        = acc.acc_req_we;
      func3_d     = FUNC3_WORD;
      addr_d      = acc.acc_addr;
      wdata_d     = acc.acc_wdata;
      starve_d    = '0;
    end else if (grant_core) begin
      owner_acc_d = 1'b0;
      we_d        = core.core_wr;
      func3_d     = core.core_func3;
      addr_d      = core.core_addr;
      wdata_d     = core.core_wdata;
      if (acc.acc_req_valid && !starved) starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_acc_q <= 1'b0;
      we_q        <= 1'b0;
      func3_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      starve_q    <= '0;
    end else begin
      owner_acc_q <= owner_acc_d;
      we_q        <= we_d;
      func3_q     <= func3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      starve_q    <= starve_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter: inputs driven after the falling
// edge, outputs sampled 1 time unit later.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dmem_core_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) core_if ();
  dmem_acc_if  #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) acc_if ();
  dmem_mem_if  #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  dmem_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .core (core_if),
    .acc  (acc_if),
    .mem  (mem_if)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn;
  logic own_acc [10];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    core_if.core_rd       = 1'b0;
    core_if.core_wr       = 1'b0;
    core_if.core_func3    = 3'b000;
    core_if.core_addr     = '0;
    core_if.core_wdata    = '0;
    acc_if.acc_req_valid  = 1'b0;
    acc_if.acc_req_we     = 1'b0;
    acc_if.acc_addr       = '0;
    acc_if.acc_wdata      = '0;
    mem_if.mem_req_ready  = 1'b0;
    mem_if.mem_rsp_valid  = 1'b0;
    mem_if.mem_rdata      = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state: accelerator request must not be acknowledged while held in reset
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    acc_if.acc_req_valid = 1'b1;
    #1;
    check("rst_acc_ready", 32'(acc_if.acc_req_ready), 32'd0);
    check("rst_mem_req",   32'(mem_if.mem_req_valid), 32'd0);
    check("rst_stall",     32'(core_if.core_stall),   32'd0);
    check("rst_mem_addr",  mem_if.mem_addr,           32'd0);
    core_if.core_rd = 1'b1;
    #1;
    check("rst_stall_core", 32'(core_if.core_stall), 32'd1);
    next_cycle();
    idle_inputs();
    reset = 1'b1;

    // Core load alone, immediate ready and response
    core_if.core_rd    = 1'b1;
    core_if.core_func3 = 3'b010;
    core_if.core_addr  = 32'h100;
    #1;
    check("ld_c0_stall", 32'(core_if.core_stall),   32'd1);
    check("ld_c0_req",   32'(mem_if.mem_req_valid), 32'd0);
    next_cycle();
    mem_if.mem_req_ready = 1'b1;
    #1;
    check("ld_c1_req",   32'(mem_if.mem_req_valid), 32'd1);
    check("ld_c1_addr",  mem_if.mem_addr,           32'h100);
    check("ld_c1_we",    32'(mem_if.mem_we),        32'd0);
    check("ld_c1_f3",    32'(mem_if.mem_func3),     32'd2);
    check("ld_c1_stall", 32'(core_if.core_stall),   32'd1);
    next_cycle();
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b1;
    mem_if.mem_rdata     = 32'hDEADBEEF;
    #1;
    check("ld_c2_stall", 32'(core_if.core_stall),   32'd0);
    check("ld_c2_rdata", core_if.core_rdata,        32'hDEADBEEF);
    check("ld_c2_accrv", 32'(acc_if.acc_rsp_valid), 32'd0);
    next_cycle();
    idle_inputs();
    #1;
    check("ld_c3_req", 32'(mem_if.mem_req_valid), 32'd0);

    // Core store and accelerator read requested together: core goes first
    core_if.core_wr      = 1'b1;
    core_if.core_func3   = 3'b001;
    core_if.core_addr    = 32'h40;
    core_if.core_wdata   = 32'h1234;
    acc_if.acc_req_valid = 1'b1;
    acc_if.acc_req_we    = 1'b0;
    acc_if.acc_addr      = 32'h80;
    #1;
    check("st_c0_accrdy", 32'(acc_if.acc_req_ready), 32'd0);
    check("st_c0_stall",  32'(core_if.core_stall),   32'd1);
    next_cycle();
    mem_if.mem_req_ready = 1'b1;
    #1;
    check("st_c1_we",    32'(mem_if.mem_we),    32'd1);
    check("st_c1_f3",    32'(mem_if.mem_func3), 32'd1);
    check("st_c1_addr",  mem_if.mem_addr,       32'h40);
    check("st_c1_wdata", mem_if.mem_wdata,      32'h1234);
    next_cycle();
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b1;
    #1;
    check("st_c2_stall", 32'(core_if.core_stall),   32'd0);
    check("st_c2_accrv", 32'(acc_if.acc_rsp_valid), 32'd0);
    next_cycle();
    mem_if.mem_rsp_valid = 1'b0;
    core_if.core_wr      = 1'b0;
    #1;
    check("st_c3_accrdy", 32'(acc_if.acc_req_ready), 32'd1);
    check("st_c3_stall",  32'(core_if.core_stall),   32'd0);
    next_cycle();
    acc_if.acc_req_valid = 1'b0;
    acc_if.acc_addr      = 32'hFFF;
    mem_if.mem_req_ready = 1'b1;
    #1;
    check("acc_c4_req",    32'(mem_if.mem_req_valid), 32'd1);
    check("acc_c4_addr",   mem_if.mem_addr,           32'h80);
    check("acc_c4_we",     32'(mem_if.mem_we),        32'd0);
    check("acc_c4_f3",     32'(mem_if.mem_func3),     32'd2);
    check("acc_c4_accrdy", 32'(acc_if.acc_req_ready), 32'd0);
    next_cycle();
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b1;
    mem_if.mem_rdata     = 32'hCAFEF00D;
    #1;
    check("acc_c5_rspv",  32'(acc_if.acc_rsp_valid), 32'd1);
    check("acc_c5_rdata", acc_if.acc_rdata,          32'hCAFEF00D);
    next_cycle();
    idle_inputs();
    #1;
    check("acc_c6_rspv", 32'(acc_if.acc_rsp_valid), 32'd0);

    // Memory back-pressure: request stays frozen while core inputs wander
    core_if.core_rd   = 1'b1;
    core_if.core_addr = 32'h10;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      core_if.core_addr = 32'h1000 + 32'(i);
      core_if.core_wr   = 1'b1;
      #1;
      check($sformatf("bp%0d_req", i),   32'(mem_if.mem_req_valid), 32'd1);
      check($sformatf("bp%0d_addr", i),  mem_if.mem_addr,           32'h10);
      check($sformatf("bp%0d_we", i),    32'(mem_if.mem_we),        32'd0);
      check($sformatf("bp%0d_stall", i), 32'(core_if.core_stall),   32'd1);
      next_cycle();
    end
    core_if.core_wr      = 1'b0;
    core_if.core_addr    = 32'h10;
    mem_if.mem_req_ready = 1'b1;
    #1;
    check("bp_rel_req", 32'(mem_if.mem_req_valid), 32'd1);
    next_cycle();
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b1;
    mem_if.mem_rdata     = 32'h5A5A5A5A;
    #1;
    check("bp_rsp_stall", 32'(core_if.core_stall), 32'd0);
    check("bp_rsp_rdata", core_if.core_rdata,      32'h5A5A5A5A);
    next_cycle();
    idle_inputs();

    // Reset while an accelerator write waits for its response
    acc_if.acc_req_valid = 1'b1;
    acc_if.acc_req_we    = 1'b1;
    acc_if.acc_addr      = 32'h500;
    acc_if.acc_wdata     = 32'hA5A5;
    #1;
    check("rw_c0_accrdy", 32'(acc_if.acc_req_ready), 32'd1);
    next_cycle();
    acc_if.acc_req_valid = 1'b0;
    mem_if.mem_req_ready = 1'b1;
    #1;
    check("rw_c1_we", 32'(mem_if.mem_we), 32'd1);
    next_cycle();
    mem_if.mem_req_ready = 1'b0;
    #1;
    reset             = 1'b0;
    core_if.core_rd   = 1'b1;
    core_if.core_addr = 32'h600;
    #1;
    check("rw_rst_req",   32'(mem_if.mem_req_valid), 32'd0);
    check("rw_rst_addr",  mem_if.mem_addr,           32'd0);
    check("rw_rst_we",    32'(mem_if.mem_we),        32'd0);
    check("rw_rst_stall", 32'(core_if.core_stall),   32'd1);
    next_cycle();
    reset                = 1'b1;
    mem_if.mem_rsp_valid = 1'b1;
    mem_if.mem_rdata     = 32'h99;
    #1;
    check("rw_late_rspv",  32'(acc_if.acc_rsp_valid), 32'd0);
    check("rw_late_stall", 32'(core_if.core_stall),   32'd1);
    next_cycle();
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_req_ready = 1'b1;
    #1;
    check("rw_core_req",  32'(mem_if.mem_req_valid), 32'd1);
    check("rw_core_addr", mem_if.mem_addr,           32'h600);
    next_cycle();
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b1;
    mem_if.mem_rdata     = 32'h77;
    #1;
    check("rw_core_stall", 32'(core_if.core_stall), 32'd0);
    check("rw_core_rdata", core_if.core_rdata,      32'h77);
    next_cycle();
    idle_inputs();

    // Spurious response with nobody requesting
    mem_if.mem_rsp_valid = 1'b1;
    #1;
    check("sp_rspv",  32'(acc_if.acc_rsp_valid), 32'd0);
    check("sp_stall", 32'(core_if.core_stall),   32'd0);
    next_cycle();
    #1;
    check("sp_req", 32'(mem_if.mem_req_valid), 32'd0);
    idle_inputs();

    // Starvation: with both always requesting, every fifth grant goes to the accelerator
    reset = 1'b0;
    #1;
    reset = 1'b1;
    core_if.core_rd      = 1'b1;
    core_if.core_addr    = 32'h200;
    acc_if.acc_req_valid = 1'b1;
    acc_if.acc_addr      = 32'h300;
    mem_if.mem_req_ready = 1'b1;
    mem_if.mem_rsp_valid = 1'b1;
    n_txn = 0;
    for (int cyc = 0; cyc < 200 && n_txn < 10; cyc++) begin
      #1;
      if (mem_if.mem_req_valid) begin
        own_acc[n_txn] = (mem_if.mem_addr == 32'h300);
        n_txn++;
      end
      next_cycle();
    end
    check("sv_txn_count", 32'(n_txn), 32'd10);
    for (int k = 0; k < n_txn; k++) begin
      check($sformatf("sv_owner%0d", k), 32'(own_acc[k]), 32'((k % 5) == 4));
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
